// File: rtl/tqvp_video_sync_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_video_sync_analyzer
// Purpose  : Measures hsync/vsync timing (line period, hsync width, lines per
//            frame, vsync width), tracks lock to a stable video format and
//            raises frame / loss-of-lock interrupts.
// Ports    : clk, rst_n (async, active-low)
//            ui_in[0] hsync_in, ui_in[1] vsync_in (pre-synchronised)
//            uo_out[1] locked (registered), other bits 0
//            address/data_in/data_write_n/data_read_n/data_out/data_ready :
//              register bus (0x00 CTRL, 0x04 HMEAS, 0x08 VMEAS, 0x0C STATUS)
//            user_interrupt : registered OR of enabled pending flags
// Options  : VSA_GLITCH_FILTER_EN - 3-sample glitch filter on both sync inputs
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_video_sync_analyzer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [15:0] C_SAT         = 16'hFFFF;
  localparam logic [5:0]  C_ADDR_CTRL   = 6'h00;
  localparam logic [5:0]  C_ADDR_HMEAS  = 6'h04;
  localparam logic [5:0]  C_ADDR_VMEAS  = 6'h08;
  localparam logic [5:0]  C_ADDR_STATUS = 6'h0C;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  logic [4:0]  r_ctrl;
  logic [15:0] r_hcnt, r_hwcnt, r_lcnt, r_vwcnt;
  logic [15:0] r_h_period, r_hsync_width, r_lines_per_frame, r_vsync_width;
  logic [15:0] r_ref_h, r_ref_l, r_frame_count;
  logic        r_h_seen, r_v_seen;
  logic        r_hs_prev, r_vs_prev;
  logic        r_frame_pend, r_lost_pend, r_locked, r_irq;
  state_t      r_state, w_state_nxt;
  logic        w_lost_set;
  logic        w_hs_lvl, w_vs_lvl;

  wire w_en    = r_ctrl[0];
  wire w_wr    = (data_write_n != 2'b11);
  wire w_w1c   = w_wr && (address == C_ADDR_STATUS);

  // Every write size covers byte lane 0, which holds all implemented CTRL bits.
  wire w_ctrl_wr = w_wr && (address == C_ADDR_CTRL);

`ifdef VSA_GLITCH_FILTER_EN
  // The filtered level follows the raw input once the raw input has been
  // sampled at the same level on three consecutive edges.
  logic [1:0] r_hs_hist, r_vs_hist;
  logic       r_hs_filt, r_vs_filt;
  assign w_hs_lvl = (ui_in[0] == r_hs_hist[0] && ui_in[0] == r_hs_hist[1]) ? ui_in[0] : r_hs_filt;
  assign w_vs_lvl = (ui_in[1] == r_vs_hist[0] && ui_in[1] == r_vs_hist[1]) ? ui_in[1] : r_vs_filt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_hist <= 2'b00;
      r_vs_hist <= 2'b00;
      r_hs_filt <= 1'b0;
      r_vs_filt <= 1'b0;
    end else begin
      r_hs_hist <= {r_hs_hist[0], ui_in[0]};
      r_vs_hist <= {r_vs_hist[0], ui_in[1]};
      r_hs_filt <= w_hs_lvl;
      r_vs_filt <= w_vs_lvl;
    end
  end
`else
  assign w_hs_lvl = ui_in[0];
  assign w_vs_lvl = ui_in[1];
`endif

  wire w_hs_act   = (w_hs_lvl == r_ctrl[1]);
  wire w_vs_act   = (w_vs_lvl == r_ctrl[2]);
  wire w_hs_lead  = w_hs_act & ~r_hs_prev;
  wire w_hs_trail = ~w_hs_act & r_hs_prev;
  wire w_vs_lead  = w_vs_act & ~r_vs_prev;
  wire w_vs_trail = ~w_vs_act & r_vs_prev;
  wire w_vlead_en = w_en & w_vs_lead;
  wire w_match    = (r_h_period == r_ref_h) && (r_lcnt == r_ref_l);

  // Measurement and counters.  r_h_seen / r_v_seen mark that a leading edge
  // has been observed since reset or enable, so that partial pulses/lines are
  // never latched as measurements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_prev <= 1'b0;  r_vs_prev <= 1'b0;
      r_hcnt <= '0;  r_hwcnt <= '0;  r_lcnt <= '0;  r_vwcnt <= '0;
      r_h_seen <= 1'b0;  r_v_seen <= 1'b0;
      r_h_period <= '0;  r_hsync_width <= '0;
      r_lines_per_frame <= '0;  r_vsync_width <= '0;
      r_ref_h <= '0;  r_ref_l <= '0;  r_frame_count <= '0;
    end else begin
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;
      if (!w_en) begin
        r_hcnt <= '0;  r_hwcnt <= '0;  r_lcnt <= '0;  r_vwcnt <= '0;
        r_h_seen <= 1'b0;  r_v_seen <= 1'b0;
      end else begin
        if (w_hs_lead) begin
          r_hcnt   <= 16'd1;
          r_h_seen <= 1'b1;
          if (r_h_seen) r_h_period <= r_hcnt;
        end else if (r_hcnt != C_SAT) begin
          r_hcnt <= r_hcnt + 16'd1;
        end
        if (w_hs_lead)                        r_hwcnt <= 16'd1;
        else if (w_hs_act && r_hwcnt != C_SAT) r_hwcnt <= r_hwcnt + 16'd1;
        if (w_hs_trail && r_h_seen)           r_hsync_width <= r_hwcnt;
        // An hsync edge coinciding with the vsync edge starts the new frame's
        // first line, so it is counted in the new frame.
        if (w_vs_lead) begin
          r_lcnt            <= {15'd0, w_hs_lead};
          r_vwcnt           <= {15'd0, w_hs_lead};
          r_lines_per_frame <= r_lcnt;
          r_v_seen          <= 1'b1;
          r_ref_h           <= r_h_period;
          r_ref_l           <= r_lcnt;
          r_frame_count     <= r_frame_count + 16'd1;
        end else begin
          if (w_hs_lead && r_lcnt != C_SAT)               r_lcnt  <= r_lcnt + 16'd1;
          if (w_vs_act && w_hs_lead && r_vwcnt != C_SAT)  r_vwcnt <= r_vwcnt + 16'd1;
        end
        if (w_vs_trail && r_v_seen) r_vsync_width <= r_vwcnt;
      end
    end
  end

  // Lock state machine
  always_comb begin
    w_state_nxt = r_state;
    w_lost_set  = 1'b0;
    if (!w_en) begin
      w_state_nxt = ST_UNLOCKED;
    end else begin
      case (r_state)
        ST_UNLOCKED: if (w_vs_lead) w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE:  if (w_vs_lead && w_match) w_state_nxt = ST_LOCKED;
        ST_LOCKED: begin
          if ((w_vs_lead && !w_match) || r_hcnt == C_SAT) begin
            w_state_nxt = ST_UNLOCKED;
            w_lost_set  = 1'b1;
          end
        end
        default: w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // Control, pending flags and registered outputs.  A set event wins over a
  // W1C in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNLOCKED;
      r_ctrl       <= '0;
      r_frame_pend <= 1'b0;
      r_lost_pend  <= 1'b0;
      r_locked     <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ctrl_wr) r_ctrl <= data_in[4:0];
      if (w_vlead_en)              r_frame_pend <= 1'b1;
      else if (w_w1c && data_in[2]) r_frame_pend <= 1'b0;
      if (w_lost_set)              r_lost_pend <= 1'b1;
      else if (w_w1c && data_in[3]) r_lost_pend <= 1'b0;
      r_locked <= (r_state == ST_LOCKED);
      r_irq    <= (r_frame_pend & r_ctrl[3]) | (r_lost_pend & r_ctrl[4]);
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      C_ADDR_CTRL:   data_out = {27'd0, r_ctrl};
      C_ADDR_HMEAS:  data_out = {r_hsync_width, r_h_period};
      C_ADDR_VMEAS:  data_out = {r_vsync_width, r_lines_per_frame};
      C_ADDR_STATUS: data_out = {r_frame_count, 12'd0, r_lost_pend, r_frame_pend, r_state};
      default:       data_out = '0;
    endcase
  end

  assign uo_out         = {6'd0, r_locked, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = r_irq;

  // Reads have no side effects, so the read strobe is not needed.
  logic w_unused;
  assign w_unused = ^{ui_in[7:2], data_in[31:5], data_read_n};

endmodule
`default_nettype wire
